fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: ADDR_W, 15, instruction address width; matches the 15-bit immediate field.
REQ-002 Parameter: BUF_DEPTH, 2, instruction buffer entries; power of two, >= 2.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port: imem_req  output  1  instruction-memory read request.
REQ-006 Port: imem_addr  output  ADDR_W  read address; valid while imem_req=1.
REQ-007 Port: imem_ack  input  1  response valid for the single outstanding request.
REQ-008 Port: imem_rdata  input  16  instruction word; sampled when imem_ack=1.
REQ-009 Port: set_pc  input  1  jump-taken strobe from the control unit.
REQ-010 Port: jump_target  input  ADDR_W  new PC; sampled when set_pc=1.
REQ-011 Port: instr  output  16  head-of-buffer instruction to the control unit.
REQ-012 Port: instr_pc  output  ADDR_W  address of instr.
REQ-013 Port: instr_valid  output  1  instr/instr_pc hold a valid entry.
REQ-014 Port: instr_ready  input  1  consumer accepts head entry when instr_valid=1.

Function
REQ-015 States SHALL be: IDLE (no request outstanding), WAIT (one request outstanding), DISCARD (one stale request outstanding; its response is dropped).
REQ-016 At most one request SHALL be outstanding; imem_req and imem_addr SHALL hold stable from assertion until the cycle imem_ack=1.
REQ-017 IDLE -> WAIT: imem_req asserted when buffer occupancy < BUF_DEPTH and set_pc=0; imem_addr = fetch_pc.
REQ-018 WAIT, imem_ack=1: push {imem_rdata, imem_addr} into the buffer; fetch_pc += 1; return to IDLE (new request possible next cycle, not the same cycle).
REQ-019 fetch_pc SHALL wrap from 2^ADDR_W-1 to 0 without flag.
REQ-020 Pop on instr_valid & instr_ready; a push and a pop in the same cycle SHALL both occur; occupancy unchanged.
REQ-021 instr_valid SHALL depend on registered state only; it SHALL NOT combinationally follow imem_ack.
REQ-022 set_pc=1 in cycle N SHALL: flush the buffer; load fetch_pc = jump_target; instr_valid=0 in N+1; override any same-cycle pop and push.
REQ-023 set_pc in WAIT with imem_ack=0 -> DISCARD; DISCARD waits for imem_ack, drops the data, -> IDLE; first target request issued in the cycle after that.
REQ-024 set_pc in WAIT with imem_ack=1 in the same cycle -> response dropped, -> IDLE; target request issued in N+1.
REQ-025 set_pc in IDLE -> target request issued in N+1.
REQ-026 Repeated set_pc SHALL keep the latest jump_target; DISCARD is not re-entered while already in DISCARD.
REQ-027 imem_ack when no request outstanding SHALL be ignored.
REQ-028 Best-case throughput: one instruction per 2 cycles with a 1-cycle-ack memory.

Reset
REQ-029 While rst_n=0 at a clock edge: state=IDLE, fetch_pc=0, buffer empty, imem_req=0, instr_valid=0, instr=0, instr_pc=0.
REQ-030 Reset mid-request SHALL abandon the outstanding request; first request after release is address 0 in the cycle after rst_n rises.

Structure
REQ-031 Shared CPU package SHALL hold: ADDR_W, instruction width 16, fetch state encoding.
REQ-032 The buffer SHALL be a sub-module, fetch_fifo (BUF_DEPTH x (16+ADDR_W), push/pop/flush, full/empty); the FSM and PC live in fetch_unit.

Verification
REQ-033 Reset release, ack in 1 cycle, instr_ready=1 -> instr_pc sequence 0,1,2,3 with the matching ROM words, instr_valid toggling every other cycle.
REQ-034 instr_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req=0 while full, no instruction lost or duplicated after release.
REQ-035 set_pc with jump_target=0x0100 while WAIT and ack delayed 3 cycles -> stale word dropped, next instr_pc=0x0100, no stale instr_valid.
REQ-036 set_pc coincident with imem_ack -> response dropped, imem_addr=target in next cycle.
REQ-037 fetch_pc at 0x7FFF -> next instr_pc=0x0000.
REQ-038 rst_n low during WAIT, stray ack after release -> ignored; first fetch address 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the instruction fetch path.
package fetch_unit_pkg;

    localparam int CPU_ADDR_W = 15;
    localparam int INSTR_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer: power-of-two depth FIFO with flush; flush wins over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory request FSM, PC, and a small buffer
// feeding the control unit. Jumps flush the buffer and discard any in-flight response.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W    = CPU_ADDR_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               set_pc,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    localparam int ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   pc_next;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_raw;
    logic                issue;
    logic                push;
    logic                pop;
    logic                buf_full;
    logic                buf_empty;
    logic [ENTRY_W-1:0]  head;

    // req_addr holds the in-flight address so imem_addr stays put even after a jump reloads fetch_pc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fetch_pc <= '0;
            req_addr <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= pc_next;
            if (issue) begin
                req_addr <= fetch_pc;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = fetch_pc;
        req_raw    = 1'b0;
        issue      = 1'b0;
        push       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!set_pc && !buf_full) begin
                    req_raw    = 1'b1;
                    issue      = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_raw = 1'b1;
                if (imem_ack) begin
                    state_next = ST_IDLE;
                    if (!set_pc) begin
                        push    = 1'b1;
                        pc_next = fetch_pc + ADDR_W'(1);
                    end
                end else if (set_pc) begin
                    state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                req_raw = 1'b1;
                if (imem_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (set_pc) begin
            pc_next = jump_target;
        end
    end

    assign imem_req    = req_raw && rst_n;
    assign imem_addr   = (state == ST_IDLE) ? fetch_pc : req_addr;
    assign instr_valid = !buf_empty;
    assign pop         = instr_valid && instr_ready && !set_pc;
    assign instr       = head[ENTRY_W-1:ADDR_W];
    assign instr_pc    = head[ADDR_W-1:0];

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (set_pc),
        .wdata ({imem_rdata, req_addr}),
        .rdata (head),
        .full  (buf_full),
        .empty (buf_empty)
    );

endmodule
